// File: rtl/ln_stats_accum.sv
// First LayerNorm stage: scales incoming activations by 2^alpha, accumulates
// sum and sum of squares per vector, then multiplies both by 1/len for E[x], E[x^2].
module ln_stats_accum #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 1,
    parameter int MAX_LEN = 1024,
    parameter int INV_W   = 8,
    localparam int LW     = $clog2(MAX_LEN),
    localparam int XS_W   = DATA_W + 3,
    localparam int SUM_W  = XS_W + LW,
    localparam int SQ_W   = 2 * XS_W + LW
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    input  logic [LANES*DATA_W-1:0] i_x,
    input  logic [1:0]              i_alpha,
    input  logic [LW:0]             i_len,
    input  logic [INV_W-1:0]        i_inv_n,
    output logic [LANES*XS_W-1:0]   o_xs,
    output logic                    o_xs_valid,
    output logic                    o_xs_last,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [SUM_W-1:0]        o_ex,
    output logic [SQ_W-1:0]         o_ex2
);
    localparam int CNT_W = LW + 2;
    localparam int LEN_W = LW + 1;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_MUL = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [LEN_W-1:0]   len_r;
    logic [1:0]         alpha_r;
    logic [INV_W-1:0]   inv_r;
    logic [SUM_W-1:0]   sum_r;
    logic [SQ_W-1:0]    sumsq_r;

    logic                     first_s;
    logic                     accept_s;
    logic                     last_s;
    logic [LEN_W-1:0]         len_in_s;
    logic [LEN_W-1:0]         len_s;
    logic [1:0]               alpha_s;
    logic [INV_W-1:0]         inv_s;
    logic [XS_W-1:0]          lane_xs_s;
    logic [2*XS_W-1:0]        lane_sq_s;
    logic [LANES*XS_W-1:0]    xs_vec_s;
    logic [SUM_W-1:0]         beat_sum_s;
    logic [SQ_W-1:0]          beat_sq_s;
    logic [SUM_W+INV_W-1:0]   ex_prod_s;
    logic [SQ_W+INV_W-1:0]    ex2_prod_s;

    // Effective vector config: live inputs on the first beat, latched copy afterwards.
    always_comb begin
        first_s  = (count_r == {CNT_W{1'b0}});
        accept_s = i_valid & o_in_ready;
        if ((i_len == {LEN_W{1'b0}}) || (i_len > LEN_W'(MAX_LEN))) begin
            len_in_s = LEN_W'(MAX_LEN);
        end else begin
            len_in_s = i_len;
        end
        if (first_s) begin
            len_s   = len_in_s;
            alpha_s = i_alpha;
            inv_s   = i_inv_n;
        end else begin
            len_s   = len_r;
            alpha_s = alpha_r;
            inv_s   = inv_r;
        end
        last_s = ((count_r + CNT_W'(LANES)) >= CNT_W'(len_s));
    end

    // Per-lane scaling and masking, reduced to one beat's sum and sum of squares.
    always_comb begin
        xs_vec_s   = {(LANES*XS_W){1'b0}};
        beat_sum_s = {SUM_W{1'b0}};
        beat_sq_s  = {SQ_W{1'b0}};
        lane_xs_s  = {XS_W{1'b0}};
        lane_sq_s  = {(2*XS_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_xs_s = XS_W'(i_x[k*DATA_W +: DATA_W]) << alpha_s;
            lane_sq_s = {{XS_W{1'b0}}, lane_xs_s} * {{XS_W{1'b0}}, lane_xs_s};
            if ((count_r + CNT_W'(k)) < CNT_W'(len_s)) begin
                xs_vec_s[k*XS_W +: XS_W] = lane_xs_s;
                beat_sum_s = beat_sum_s + SUM_W'(lane_xs_s);
                beat_sq_s  = beat_sq_s + SQ_W'(lane_sq_s);
            end else begin
                xs_vec_s[k*XS_W +: XS_W] = {XS_W{1'b0}};
            end
        end
    end

    // Reciprocal-length products; the fraction bits are dropped when registered.
    always_comb begin
        ex_prod_s  = {{INV_W{1'b0}}, sum_r} * {{SUM_W{1'b0}}, inv_r};
        ex2_prod_s = {{INV_W{1'b0}}, sumsq_r} * {{SQ_W{1'b0}}, inv_r};
    end

    // Control FSM, accumulators and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_ACC;
            count_r    <= {CNT_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            alpha_r    <= 2'd0;
            inv_r      <= {INV_W{1'b0}};
            sum_r      <= {SUM_W{1'b0}};
            sumsq_r    <= {SQ_W{1'b0}};
            o_in_ready <= 1'b1;
            o_xs       <= {(LANES*XS_W){1'b0}};
            o_xs_valid <= 1'b0;
            o_xs_last  <= 1'b0;
            o_valid    <= 1'b0;
            o_ex       <= {SUM_W{1'b0}};
            o_ex2      <= {SQ_W{1'b0}};
        end else begin
            o_xs_valid <= accept_s;
            o_xs_last  <= accept_s & last_s;
            if (accept_s) begin
                o_xs <= xs_vec_s;
            end
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        sum_r   <= sum_r + beat_sum_s;
                        sumsq_r <= sumsq_r + beat_sq_s;
                        count_r <= count_r + CNT_W'(LANES);
                        if (first_s) begin
                            len_r   <= len_in_s;
                            alpha_r <= i_alpha;
                            inv_r   <= i_inv_n;
                        end
                        if (last_s) begin
                            state_r    <= ST_MUL;
                            o_in_ready <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    o_ex    <= ex_prod_s[SUM_W+INV_W-1:INV_W];
                    o_ex2   <= ex2_prod_s[SQ_W+INV_W-1:INV_W];
                    sum_r   <= {SUM_W{1'b0}};
                    sumsq_r <= {SQ_W{1'b0}};
                    count_r <= {CNT_W{1'b0}};
                    o_valid <= 1'b1;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        o_in_ready <= 1'b1;
                        state_r    <= ST_ACC;
                    end
                end
                default: begin
                    o_valid    <= 1'b0;
                    o_in_ready <= 1'b1;
                    state_r    <= ST_ACC;
                end
            endcase
        end
    end
endmodule
